vga_scan_timing: RTL and testbench

- Generates 640x480@60 VGA scan timing from the 50 MHz system clock.
- Produces the DrawX/DrawY pixel coordinates consumed by the colour mapper, then registers the mapper's combinational RGB answer with matching sync/blank so the DAC sees aligned signals.
- Also issues a once-per-frame pulse for game-state (ball/block) update logic.

---
 rtl/vga_scan_timing.sv | 180 ++++++++++++++++++
 tb/tb_vga_scan_timing.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_timing.sv
// -----------------------------------------------------------------------------
// vga_scan_timing
//
// Purpose:
//   640x480@60 VGA scan timing generator running from the 50 MHz system clock.
//   A small divider produces one pixel strobe every CLK_DIV clocks. Horizontal
//   and vertical counters walk the full raster (visible area plus porches and
//   sync). The current counter values are presented as DrawX/DrawY to the
//   colour mapper. The mapper's combinational RGB answer is registered one
//   pixel later, together with blank and both syncs, so the DAC always sees
//   mutually aligned colour and timing. A one-clock pulse marks the last pixel
//   of each frame for game-state update logic.
//
// Ports:
//   Clk          in   system clock (50 MHz)
//   Reset        in   synchronous, active-low reset
//   Red_in       in   [7:0] mapper red for the current DrawX/DrawY
//   Green_in     in   [7:0] mapper green
//   Blue_in      in   [7:0] mapper blue
//   DrawX        out  [9:0] horizontal count, 0..H_TOTAL-1
//   DrawY        out  [9:0] vertical count, 0..V_TOTAL-1
//   pixel_en     out  one-clock strobe per pixel period
//   frame_start  out  one-clock pulse on the last pixel of each frame
//   VGA_CLK      out  pixel clock to the DAC, rising mid-pixel
//   VGA_HS       out  horizontal sync, active-low, registered
//   VGA_VS       out  vertical sync, active-low, registered
//   VGA_BLANK_N  out  low outside the visible area, registered
//   VGA_SYNC_N   out  tied low (no sync-on-green)
//   VGA_R/G/B    out  [7:0] registered colour to the DAC
//
// Configuration:
//   VGA_BORDER_TEST_EN - when defined, the outermost visible rows and columns
//   are forced to white regardless of the mapper inputs, for checking monitor
//   framing. When undefined, visible pixels always pass the inputs through.
//
// CLK_DIV must be even and at least 2. Totals must fit the 10-bit counters.
// -----------------------------------------------------------------------------
module vga_scan_timing #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int CLK_DIV   = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] Red_in,
    input  logic [7:0] Green_in,
    input  logic [7:0] Blue_in,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       pixel_en,
    output logic       frame_start,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = $clog2(CLK_DIV);

    // Counter-width copies of the timing landmarks, so every compare is
    // between equal-width operands.
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_next;
    logic [9:0]       hc;
    logic [9:0]       vc;
    logic             h_last;
    logic             v_last;
    logic             visible;
    logic             hs_active;
    logic             vs_active;
    logic [7:0]       r_sel;
    logic [7:0]       g_sel;
    logic [7:0]       b_sel;

    assign pixel_en    = (div == DIV_LAST);
    assign h_last      = (hc == H_LAST);
    assign v_last      = (vc == V_LAST);
    assign frame_start = pixel_en && h_last && v_last;

    assign DrawX      = hc;
    assign DrawY      = vc;
    assign VGA_SYNC_N = 1'b0;

    assign visible   = (hc < H_VIS) && (vc < V_VIS);
    assign hs_active = (hc >= HS_START) && (hc < HS_END);
    assign vs_active = (vc >= VS_START) && (vc < VS_END);

    // The divider wraps on the pixel strobe, so it never needs a separate
    // terminal-count compare.
    assign div_next = pixel_en ? '0 : div + 1'b1;

    // Colour selection for the pixel currently addressed by hc/vc.
    always_comb begin
        // NOTE: every always_comb output gets an unconditional default first;
        // a path that leaves one unassigned would infer a latch.
        r_sel = '0;
        g_sel = '0;
        b_sel = '0;
        if (visible) begin
            r_sel = Red_in;
            g_sel = Green_in;
            b_sel = Blue_in;
        end
`ifdef VGA_BORDER_TEST_EN
        if (visible && (hc == '0 || hc == H_VIS - 10'd1 ||
                        vc == '0 || vc == V_VIS - 10'd1)) begin
            r_sel = 8'hFF;
            g_sel = 8'hFF;
            b_sel = 8'hFF;
        end
`endif
    end

    // NOTE: Reset is sampled only on the clock edge, so it appears in the
    // body of the block, not in the sensitivity list.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            div         <= '0;
            hc          <= '0;
            vc          <= '0;
            VGA_CLK     <= 1'b0;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            div <= div_next;

            // Registered from div_next: rises CLK_DIV/2 clocks after each
            // output update, putting the DAC sampling edge mid-pixel.
            VGA_CLK <= (div_next >= DIV_HALF);

            if (pixel_en) begin
                if (h_last) begin
                    hc <= '0;
                    vc <= v_last ? '0 : vc + 10'd1;
                end else begin
                    hc <= hc + 10'd1;
                end

                // Output stage captures the pixel being left, so colour,
                // blank and syncs all carry the same one-pixel latency.
                VGA_R       <= r_sel;
                VGA_G       <= g_sel;
                VGA_B       <= b_sel;
                VGA_BLANK_N <= visible;
                VGA_HS      <= ~hs_active;
                VGA_VS      <= ~vs_active;
            end
        end
    end

endmodule

// File: tb/tb_vga_scan_timing.sv
// -----------------------------------------------------------------------------
// tb_vga_scan_timing
//
// Self-checking bench for vga_scan_timing. Horizontal timing is the standard
// 800-pixel line; the vertical raster is shortened (14 lines) so several whole
// frames fit in a short run. The reference model tracks only the number of
// clocks since reset release and derives pixel index, coordinates and the
// expected registered outputs from it arithmetically. Additional measurements
// time sync widths, line period and frame-pulse spacing directly.
// -----------------------------------------------------------------------------
module tb_vga_scan_timing;

    localparam int HV  = 640;
    localparam int HFP = 16;
    localparam int HSW = 96;
    localparam int HBP = 48;
    localparam int VV  = 8;
    localparam int VFP = 2;
    localparam int VSW = 2;
    localparam int VBP = 2;
    localparam int CD  = 2;
    localparam int HT  = HV + HFP + HSW + HBP;
    localparam int VT  = VV + VFP + VSW + VBP;
    localparam int FRAME_PIX = HT * VT;

    logic       clk;
    logic       rst_n;
    logic [7:0] red_in, green_in, blue_in;
    logic [9:0] draw_x, draw_y;
    logic       pixel_en, frame_start, vga_clk, vga_hs, vga_vs;
    logic       vga_blank_n, vga_sync_n;
    logic [7:0] vga_r, vga_g, vga_b;

    vga_scan_timing #(
        .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .CLK_DIV(CD)
    ) dut (
        .Clk        (clk),
        .Reset      (rst_n),
        .Red_in     (red_in),
        .Green_in   (green_in),
        .Blue_in    (blue_in),
        .DrawX      (draw_x),
        .DrawY      (draw_y),
        .pixel_en   (pixel_en),
        .frame_start(frame_start),
        .VGA_CLK    (vga_clk),
        .VGA_HS     (vga_hs),
        .VGA_VS     (vga_vs),
        .VGA_BLANK_N(vga_blank_n),
        .VGA_SYNC_N (vga_sync_n),
        .VGA_R      (vga_r),
        .VGA_G      (vga_g),
        .VGA_B      (vga_b)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: clocks since release, plus the expected output stage.
    int         n = 0;
    logic [7:0] e_r = 8'h00, e_g = 8'h00, e_b = 8'h00;
    logic       e_hs = 1'b1, e_vs = 1'b1, e_bl = 1'b0;
    bit         late_phase = 1'b0;

    // Measurement state.
    int  last_hs_fall = -1, hs_low = 0, last_vs_fall = -1, vs_low = 0;
    int  last_fs = -1, fs_count = 0;
    bit  hs_run = 1'b0, vs_run = 1'b0;
    logic prev_hs = 1'b1, prev_vs = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            if (n_fail <= 30)
                $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
                       tag, cyc, obs, exp);
        end
    endtask

    task automatic clear_measurements();
        last_hs_fall = -1; hs_low = 0; hs_run = 1'b0;
        last_vs_fall = -1; vs_low = 0; vs_run = 1'b0;
        last_fs = -1;
        prev_hs = 1'b1; prev_vs = 1'b1;
    endtask

    // One clock: update the model across the edge, check at the falling edge,
    // take timing measurements, then present new mapper inputs.
    task automatic tick();
        bit  pe_before;
        int  p, x, y;
        bit  vis, border, exp_fs;
        pe_before = (n % CD == CD - 1);
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            n = 0;
            e_r = 8'h00; e_g = 8'h00; e_b = 8'h00;
            e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b0;
        end else begin
            if (pe_before) begin
                p = n / CD;
                x = p % HT;
                y = (p / HT) % VT;
                vis = (x < HV) && (y < VV);
`ifdef VGA_BORDER_TEST_EN
                border = vis && (x == 0 || x == HV - 1 || y == 0 || y == VV - 1);
`else
                border = 1'b0;
`endif
                e_r  = border ? 8'hFF : (vis ? red_in   : 8'h00);
                e_g  = border ? 8'hFF : (vis ? green_in : 8'h00);
                e_b  = border ? 8'hFF : (vis ? blue_in  : 8'h00);
                e_bl = vis;
                e_hs = !(x >= HV + HFP && x < HV + HFP + HSW);
                e_vs = !(y >= VV + VFP && y < VV + VFP + VSW);
            end
            n++;
        end
        @(negedge clk);

        p = n / CD;
        exp_fs = (n % CD == CD - 1) && (p % FRAME_PIX == FRAME_PIX - 1);
        check("draw_x",      32'(draw_x),      32'(p % HT));
        check("draw_y",      32'(draw_y),      32'((p / HT) % VT));
        check("pixel_en",    32'(pixel_en),    32'(n % CD == CD - 1));
        check("frame_start", 32'(frame_start), 32'(exp_fs));
        check("vga_clk",     32'(vga_clk),     32'((n % CD) >= CD / 2));
        check("vga_hs",      32'(vga_hs),      32'(e_hs));
        check("vga_vs",      32'(vga_vs),      32'(e_vs));
        check("blank_n",     32'(vga_blank_n), 32'(e_bl));
        check("sync_n",      32'(vga_sync_n),  32'(0));
        check("vga_r",       32'(vga_r),       32'(e_r));
        check("vga_g",       32'(vga_g),       32'(e_g));
        check("vga_b",       32'(vga_b),       32'(e_b));

        if (!rst_n) begin
            clear_measurements();
        end else begin
            // Horizontal sync width and line period.
            if (prev_hs && !vga_hs) begin
                if (last_hs_fall >= 0)
                    check("line_period", 32'(cyc - last_hs_fall), 32'(HT * CD));
                last_hs_fall = cyc;
                hs_low = 0;
                hs_run = 1'b1;
            end
            if (!vga_hs) hs_low++;
            if (!prev_hs && vga_hs && hs_run)
                check("hs_width", 32'(hs_low), 32'(HSW * CD));
            // Vertical sync width.
            if (prev_vs && !vga_vs) begin
                vs_low = 0;
                vs_run = 1'b1;
            end
            if (!vga_vs) vs_low++;
            if (!prev_vs && vga_vs && vs_run)
                check("vs_width", 32'(vs_low), 32'(VSW * HT * CD));
            // Frame pulse spacing.
            if (frame_start) begin
                fs_count++;
                if (last_fs >= 0)
                    check("frame_period", 32'(cyc - last_fs), 32'(FRAME_PIX * CD));
                last_fs = cyc;
            end
            prev_hs = vga_hs;
            prev_vs = vga_vs;
        end

        // Mapper inputs: a fixed colour for the first two lines, a constant
        // 8'h12 throughout the second frame, random (changing every clock)
        // elsewhere.
        p = n / CD;
        if (!late_phase && p < 2 * HT) begin
            red_in = 8'h4F; green_in = 8'h00; blue_in = 8'h44;
        end else if (!late_phase && (p / FRAME_PIX) == 1) begin
            red_in = 8'h12; green_in = 8'h12; blue_in = 8'h12;
        end else begin
            red_in   = 8'($urandom);
            green_in = 8'($urandom);
            blue_in  = 8'($urandom);
        end
    endtask

    initial begin
        int guard;
        rst_n    = 1'b0;
        red_in   = 8'h00;
        green_in = 8'h00;
        blue_in  = 8'h00;

        // Reset held for three clocks, then released.
        repeat (3) tick();
        rst_n = 1'b1;

        // Two full frames plus a margin: lines, syncs, frame pulses, colours.
        while (n < 2 * FRAME_PIX * CD + 200) tick();
        check("frame_pulses", 32'(fs_count), 32'(2));

        // Walk to DrawX=300, DrawY=5 and reset mid-frame.
        late_phase = 1'b1;
        guard = 0;
        while (!(draw_x == 10'd300 && draw_y == 10'd5 && !pixel_en) &&
               guard < 2 * FRAME_PIX * CD) begin
            tick();
            guard++;
        end
        check("reached_reset_point", 32'(guard < 2 * FRAME_PIX * CD), 32'(1));
        rst_n = 1'b0;
        tick();
        check("mid_reset_x", 32'(draw_x), 32'(0));
        check("mid_reset_y", 32'(draw_y), 32'(0));
        rst_n = 1'b1;

        // Scan resumes from (0,0); run a little over two lines.
        repeat (2 * HT * CD + 20) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
